instr_fetch_unit: RTL and testbench

- Fetch stage for the multicycle RV32I core; sits directly upstream of the control FSM.
- Owns PC, old PC and the instruction register, and issues instruction-memory reads over a req/ack handshake.
- Supplies opcode and instruction to the FSM and decoder, and applies PC redirects from the FSM's pc_update/pc_src.
- Exposes fetch_busy so the FSM can stall while memory is slow.

---
 rtl/instr_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns pc/old_pc/ir and runs the imem req/ack handshake.
// Optional FETCH_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_update,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic        fetch_busy,
  output logic        fetch_valid,
  output logic        misaligned_err,
  output logic        fetch_err
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        jump, jump_ok;
  logic [31:0] redir_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ferr_q, ferr_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign jump    = pc_update & pc_src;
  assign jump_ok = jump & (pc_target[1:0] == 2'b00);

  // newest redirect wins, including one arriving with the ack
  assign redir_pc = jump_ok ? pc_target : tgt_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    old_pc_d = old_pc_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    tgt_d    = tgt_q;
    pend_d   = pend_q;
    req_d    = req_q;
    valid_d  = 1'b0;
    mis_d    = mis_q | (jump & ~jump_ok);
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    ferr_d   = ferr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (jump_ok) pc_d = pc_target;
        if (fetch_start) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
          pend_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (jump_ok) begin
          pend_d = 1'b1;
          tgt_d  = pc_target;
        end
        if (imem_ack) begin
          instr_d  = imem_rdata;
          old_pc_d = pc_q;
          pc_d     = (jump_ok | pend_q) ? redir_pc : pc_q + 32'd4;
          pend_d   = 1'b0;
          req_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == LAST) begin
          if (jump_ok | pend_q) pc_d = redir_pc;
          pend_d  = 1'b0;
          req_d   = 1'b0;
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      old_pc_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      addr_q   <= RESET_PC;
      tgt_q    <= RESET_PC;
      pend_q   <= 1'b0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= '0;
      ferr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      tgt_q    <= tgt_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
      ferr_q   <= ferr_d;
`endif
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[6:0];
  assign pc             = pc_q;
  assign old_pc         = old_pc_q;
  assign fetch_busy     = (state_q == REQ);
  assign fetch_valid    = valid_q;
  assign misaligned_err = mis_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err      = ferr_q;
`else
  assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scoreboard of fetch results checked
// whenever fetch_valid pulses, plus direct handshake/boundary checks.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start, pc_update, pc_src, imem_ack;
  logic [31:0] pc_target, imem_rdata;
  logic        imem_req, fetch_busy, fetch_valid;
  logic        misaligned_err, fetch_err;
  logic [31:0] imem_addr, instr, pc, old_pc;
  logic [6:0]  opcode;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [31:0] pc;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errs = 0;
  int          n_valid = 0;
  logic [31:0] m_pc = 32'h0;
  logic        m_mis = 1'b0;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_start   (fetch_start),
    .pc_update     (pc_update),
    .pc_src        (pc_src),
    .pc_target     (pc_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .pc            (pc),
    .old_pc        (old_pc),
    .fetch_busy    (fetch_busy),
    .fetch_valid   (fetch_valid),
    .misaligned_err(misaligned_err),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && fetch_valid === 1'b1) begin
      n_valid++;
      if (sbq.size() == 0) begin
        check("spurious_valid", 32'(fetch_valid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_instr", instr, e.instr);
        check("sb_opcode", 32'(opcode), 32'(e.instr[6:0]));
        check("sb_old_pc", old_pc, e.old_pc);
        check("sb_pc", pc, e.pc);
      end
    end
  end

  task automatic jump(input logic [31:0] t);
    pc_update = 1'b1;
    pc_src    = 1'b1;
    pc_target = t;
    tick();
    pc_update = 1'b0;
    if (t[1:0] == 2'b00) m_pc = t;
    else m_mis = 1'b1;
    check("jump_pc", pc, m_pc);
    check("jump_mis", 32'(misaligned_err), 32'(m_mis));
  endtask

  // n_redir redirects (targets ta, tb) are issued in the first wait cycles
  task automatic fetch(input logic [31:0] data, input int wait_n,
                       input int n_redir, input logic [31:0] ta,
                       input logic [31:0] tb);
    int          v0;
    logic        pend;
    logic [31:0] ptgt, nxt, t;
    v0   = n_valid;
    pend = 1'b0;
    ptgt = 32'h0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("req_on", 32'(imem_req), 32'd1);
    check("req_addr", imem_addr, m_pc);
    check("busy_on", 32'(fetch_busy), 32'd1);
    for (int i = 0; i < wait_n; i++) begin
      fetch_start = i[0];
      if (i < n_redir) begin
        t = (i == 0) ? ta : tb;
        pc_update = 1'b1;
        pc_src    = 1'b1;
        pc_target = t;
        if (t[1:0] == 2'b00) begin
          pend = 1'b1;
          ptgt = t;
        end else begin
          m_mis = 1'b1;
        end
      end
      tick();
      pc_update = 1'b0;
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, m_pc);
      check("busy_hold", 32'(fetch_busy), 32'd1);
      check("no_early_valid", 32'(fetch_valid), 32'd0);
    end
    fetch_start = 1'b0;
    nxt = pend ? ptgt : m_pc + 32'd4;
    imem_ack   = 1'b1;
    imem_rdata = data;
    sbq.push_back('{data, m_pc, nxt});
    tick();
    imem_ack = 1'b0;
    m_pc = nxt;
    check("valid_pulse", 32'(fetch_valid), 32'd1);
    check("req_off", 32'(imem_req), 32'd0);
    check("busy_off", 32'(fetch_busy), 32'd0);
    tick();
    check("valid_once", 32'(fetch_valid), 32'd0);
    check("one_valid", 32'(n_valid - v0), 32'd1);
    check("mis_flag", 32'(misaligned_err), 32'(m_mis));
  endtask

  initial begin
    reset       = 1'b0;
    fetch_start = 1'b0;
    pc_update   = 1'b0;
    pc_src      = 1'b0;
    pc_target   = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_old_pc", old_pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_mis", 32'(misaligned_err), 32'd0);
    check("rst_ferr", 32'(fetch_err), 32'd0);
    reset = 1'b1;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("idle_ack_ignored", 32'(fetch_valid), 32'd0);

    fetch(32'h0000_0033, 0, 0, 32'h0, 32'h0);
    fetch(32'h00a0_0093, 5, 0, 32'h0, 32'h0);
    fetch(32'h0000_0063, 4, 2, 32'h300, 32'h200);
    check("redir_req_pc", pc, 32'h200);
    check("redir_req_old", old_pc, 32'h8);

    jump(32'h100);
    fetch(32'h0000_0013, 1, 0, 32'h0, 32'h0);

    pc_update = 1'b1;
    pc_src    = 1'b0;
    pc_target = 32'h500;
    tick();
    pc_update = 1'b0;
    check("inc_noop", pc, m_pc);

    jump(32'h102);
    check("mis_pc_kept", pc, 32'h104);
    fetch(32'h0000_0037, 2, 1, 32'h201, 32'h0);
    check("mis_sticky", 32'(misaligned_err), 32'd1);

    jump(32'hFFFF_FFFC);
    fetch(32'h0000_006f, 0, 0, 32'h0, 32'h0);
    check("pc_wrap", pc, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    begin
      logic [31:0] ir0;
      int          v0;
      ir0 = instr;
      v0  = n_valid;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      for (int i = 0; i < 15; i++) begin
        tick();
        check("to_req_hold", 32'(imem_req), 32'd1);
      end
      tick();
      check("to_req_drop", 32'(imem_req), 32'd0);
      check("to_ferr", 32'(fetch_err), 32'd1);
      check("to_instr", instr, ir0);
      check("to_pc", pc, m_pc);
      check("to_busy", 32'(fetch_busy), 32'd0);
      tick();
      check("to_no_valid", 32'(n_valid - v0), 32'd0);
    end
`else
    check("ferr_tied", 32'(fetch_err), 32'd0);
`endif

    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("pre_rst_req", 32'(imem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_pc", pc, 32'h0);
    check("arst_old_pc", old_pc, 32'h0);
    check("arst_instr", instr, 32'h0000_0013);
    check("arst_busy", 32'(fetch_busy), 32'd0);
    check("arst_mis", 32'(misaligned_err), 32'd0);
    check("arst_ferr", 32'(fetch_err), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
